// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the oversampling UART receiver.
//  - rx_state_e   : receiver FSM states
//  - rx_status_t  : per-character error status held alongside received data
//  - OvsDefault   : default oversample ticks per bit
//  - maj3()       : 2-of-3 majority used by the bit voter
package uart_pkg;

    localparam int unsigned OvsDefault = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

    typedef struct packed {
        logic frame_err;
        logic parity_err;
    } rx_status_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: character output channel of the UART receiver.
//  data       received character (DATA_W bits)
//  valid      data holds an unread character
//  ready      consumer accepts data when valid & ready
//  frame_err  qualifies data: stop bit sampled 0
//  parity_err qualifies data: parity mismatch
//  overrun    1-cycle pulse: a completed frame was dropped
// master = receiver side, slave = consumer side.
interface uart_rx_os_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              frame_err;
    logic              parity_err;
    logic              overrun;

    modport master (
        output data, valid, frame_err, parity_err, overrun,
        input  ready
    );

    modport slave (
        input  data, valid, frame_err, parity_err, overrun,
        output ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator.
//  i_clk   system clock
//  i_rst   asynchronous active-low reset
//  i_baud  divider select (0..3 -> DIV0..DIV3)
//  i_clr   latch divider from i_baud and zero the counter (start-bit detect)
//  i_en    count enable
//  o_tick  1-cycle pulse each time the counter wraps (every DIV enabled cycles)
module uart_baud_tick #(
    parameter int unsigned DIV0 = 27,
    parameter int unsigned DIV1 = 54,
    parameter int unsigned DIV2 = 325,
    parameter int unsigned DIV3 = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_baud,
    input  logic       i_clr,
    input  logic       i_en,
    output logic       o_tick
);
    localparam int unsigned Max01  = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int unsigned Max23  = (DIV2 > DIV3) ? DIV2 : DIV3;
    localparam int unsigned DivMax = (Max01 > Max23) ? Max01 : Max23;
    localparam int unsigned CntW   = (DivMax > 2) ? $clog2(DivMax) : 1;

    logic [CntW-1:0] div_sel;
    logic [CntW-1:0] div_m1_q;
    logic [CntW-1:0] cnt_q;

    always_comb begin
        div_sel = CntW'(DIV0 - 1);
        unique case (i_baud)
            2'd0: div_sel = CntW'(DIV0 - 1);
            2'd1: div_sel = CntW'(DIV1 - 1);
            2'd2: div_sel = CntW'(DIV2 - 1);
            2'd3: div_sel = CntW'(DIV3 - 1);
            default: div_sel = CntW'(DIV0 - 1);
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            div_m1_q <= '0;
            cnt_q    <= '0;
        end else if (i_clr) begin
            div_m1_q <= div_sel;
            cnt_q    <= '0;
        end else if (i_en) begin
            cnt_q <= (cnt_q == div_m1_q) ? '0 : cnt_q + 1'b1;
        end
    end

    assign o_tick = i_en & (cnt_q == div_m1_q);

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with 2-of-3 mid-bit vote, runtime baud
// select, framing/break detection and a one-entry output holding register.
//  i_clk         system clock
//  i_rst         asynchronous active-low reset
//  i_baud        baud select, captured at start-bit detect
//  i_parity_odd  0 = even, 1 = odd parity, captured at start detect (UART_RX_PARITY_EN only)
//  i_rx          serial line, asynchronous, idle high
//  o_busy        FSM not idle
//  rx_if         character channel (data/valid/ready/frame_err/parity_err/overrun)
// Build option: define UART_RX_PARITY_EN to add a parity bit after the data bits;
// without it there is no parity state and parity_err is tied 0.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned OVS       = OvsDefault,
    parameter int unsigned BAUD_DIV0 = 27,
    parameter int unsigned BAUD_DIV1 = 54,
    parameter int unsigned BAUD_DIV2 = 325,
    parameter int unsigned BAUD_DIV3 = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [1:0]    i_baud,
`ifdef UART_RX_PARITY_EN
    input  logic          i_parity_odd,
`endif
    input  logic          i_rx,
    output logic          o_busy,
    uart_rx_os_if.master  rx_if
);
    localparam int unsigned OsW  = $clog2(OVS);
    localparam int unsigned BitW = $clog2(DATA_W);
    localparam int unsigned Half = OVS / 2;

    rx_state_e state_q, state_d;

    logic              rx_meta_q, rx_s_q, rx_prev_q;
    logic              tick;
    logic [OsW-1:0]    os_cnt_q;
    logic [BitW-1:0]   bit_cnt_q;
    logic [1:0]        samp_q;
    logic [DATA_W-1:0] shift_q;
    logic              vote;
    logic              decide;
    logic              bit_end;

    logic              start_det;
    logic              tick_en;
    logic              commit;
    logic              shift_en;
    logic              par_err;
    rx_status_t        status_d, status_q;

    // Synchroniser idles high so reset release never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    uart_baud_tick #(
        .DIV0 (BAUD_DIV0),
        .DIV1 (BAUD_DIV1),
        .DIV2 (BAUD_DIV2),
        .DIV3 (BAUD_DIV3)
    ) u_baud_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_baud (i_baud),
        .i_clr  (start_det),
        .i_en   (tick_en),
        .o_tick (tick)
    );

    // os_cnt_q holds (tick number within bit - 1), so the samples at ticks
    // Half-1, Half, Half+1 happen when os_cnt_q is Half-2, Half-1, Half.
    assign vote    = maj3(samp_q[0], samp_q[1], rx_s_q);
    assign decide  = tick & (os_cnt_q == OsW'(Half));
    assign bit_end = tick & (os_cnt_q == OsW'(OVS - 1));

    // ---------------- FSM: state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rx_prev_q && !rx_s_q) state_d = StStart;
            end
            StStart: begin
                if (decide && vote) state_d = StIdle;  // false start
                else if (bit_end)   state_d = StData;
            end
            StData: begin
                if (bit_end && (bit_cnt_q == BitW'(DATA_W - 1))) begin
`ifdef UART_RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
            StParity: begin
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (decide) state_d = vote ? StIdle : StBreak;
            end
            StBreak: begin
                if (rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs
    always_comb begin
        start_det = 1'b0;
        tick_en   = 1'b0;
        commit    = 1'b0;
        shift_en  = 1'b0;
        o_busy    = (state_q != StIdle);
        unique case (state_q)
            StIdle:   start_det = rx_prev_q & ~rx_s_q;
            StStart:  tick_en = 1'b1;
            StData: begin
                tick_en  = 1'b1;
                shift_en = decide;
            end
            StParity: tick_en = 1'b1;
            StStop: begin
                tick_en = 1'b1;
                commit  = decide;
            end
            default: ;
        endcase
    end

    // ---------------- Bit timing, voting and shift register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            samp_q    <= 2'b11;
            shift_q   <= '0;
        end else begin
            if (start_det) begin
                os_cnt_q  <= '0;
                bit_cnt_q <= '0;
            end else if (tick) begin
                os_cnt_q <= bit_end ? '0 : os_cnt_q + 1'b1;
                if (bit_end && (state_q == StData)) bit_cnt_q <= bit_cnt_q + 1'b1;
                if (os_cnt_q == OsW'(Half - 2)) samp_q[0] <= rx_s_q;
                if (os_cnt_q == OsW'(Half - 1)) samp_q[1] <= rx_s_q;
            end
            if (shift_en) shift_q <= {vote, shift_q[DATA_W-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_odd_q;
    logic par_err_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            par_odd_q <= 1'b0;
            par_err_q <= 1'b0;
        end else if (start_det) begin
            par_odd_q <= i_parity_odd;
            par_err_q <= 1'b0;
        end else if ((state_q == StParity) && decide) begin
            // XOR of data and parity bit must equal 1 for odd, 0 for even.
            par_err_q <= ((^shift_q) ^ vote) != par_odd_q;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign status_d = '{frame_err: ~vote, parity_err: par_err};

    // ---------------- Holding register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_if.data    <= '0;
            rx_if.valid   <= 1'b0;
            rx_if.overrun <= 1'b0;
            status_q      <= '0;
        end else begin
            rx_if.overrun <= 1'b0;
            if (commit) begin
                if (rx_if.valid && !rx_if.ready) begin
                    rx_if.overrun <= 1'b1;  // keep the unread character
                end else begin
                    rx_if.data  <= shift_q;
                    rx_if.valid <= 1'b1;
                    status_q    <= status_d;
                end
            end else if (rx_if.valid && rx_if.ready) begin
                rx_if.valid <= 1'b0;
            end
        end
    end

    assign rx_if.frame_err  = status_q.frame_err;
    assign rx_if.parity_err = status_q.parity_err;

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;
    localparam int unsigned DataW = 8;
    localparam int unsigned Ovs   = 16;
    localparam int unsigned Div0  = 27;
    localparam int unsigned Div3  = 2;
    localparam int unsigned BitClk = Ovs * Div3;

    typedef struct packed {
        logic [7:0] data;
        logic       frame_err;
        logic       parity_err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] baud;
    logic       rx;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd;
`endif

    uart_rx_os_if #(.DATA_W(DataW)) rx_if ();

    uart_rx_os #(
        .DATA_W    (DataW),
        .OVS       (Ovs),
        .BAUD_DIV0 (Div0),
        .BAUD_DIV1 (54),
        .BAUD_DIV2 (325),
        .BAUD_DIV3 (Div3)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_baud       (baud),
`ifdef UART_RX_PARITY_EN
        .i_parity_odd (parity_odd),
`endif
        .i_rx         (rx),
        .o_busy       (busy),
        .rx_if        (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_chars  = 0;
    int   n_ovr    = 0;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard monitor: every accepted character is compared to the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rx_if.overrun) n_ovr++;
        if (rst_n && rx_if.valid && rx_if.ready) begin
            n_chars++;
            check("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("rx_data", 32'(rx_if.data), 32'(e.data));
                check("rx_frame_err", 32'(rx_if.frame_err), 32'(e.frame_err));
                check("rx_parity_err", 32'(rx_if.parity_err), 32'(e.parity_err));
            end
        end
    end

    // Drives start, data (LSB first), optional parity and stop; glitch_bit inverts
    // the line for one tick at the middle of that data bit; stops after max_bits bits.
    task automatic send_frame(input logic [7:0] data, input int div, input logic par_en,
                              input logic par_bit, input logic stop_bit,
                              input int glitch_bit, input int max_bits);
        int         bit_clks;
        int         n;
        logic [11:0] seq;
        bit_clks = Ovs * div;
        seq      = '0;
        seq[0]   = 1'b0;
        for (int i = 0; i < 8; i++) seq[1+i] = data[i];
        n = 9;
        if (par_en) begin
            seq[n] = par_bit;
            n++;
        end
        seq[n] = stop_bit;
        n++;
        if (max_bits < n) n = max_bits;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < bit_clks; c++) begin
                @(negedge clk);
                rx = seq[b];
                if ((b == glitch_bit + 1) && (c >= bit_clks / 2 - 1) && (c <= bit_clks / 2))
                    rx = ~seq[b];
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic idle_bits(input int nbits);
        rx = 1'b1;
        repeat (nbits * BitClk) @(negedge clk);
    endtask

    int chars_before;

    initial begin
        rst_n       = 1'b0;
        baud        = 2'd3;
        rx          = 1'b1;
        rx_if.ready = 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_odd  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rx_if.valid), 32'd0);
        check("rst_data", 32'(rx_if.data), 32'd0);
        check("rst_frame_err", 32'(rx_if.frame_err), 32'd0);
        check("rst_parity_err", 32'(rx_if.parity_err), 32'd0);
        check("rst_overrun", 32'(rx_if.overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 0xA5 at baud select 0
        baud = 2'd0;
        chars_before = n_chars;
        sb_q.push_back('{data: 8'hA5, frame_err: 1'b0, parity_err: 1'b0});
        send_frame(8'hA5, Div0, 1'b0, 1'b0, 1'b1, -1, 99);
        wait_idle("t1_idle", 4000);
        repeat (4) @(negedge clk);
        check("t1_one_char", 32'(n_chars - chars_before), 32'd1);
        baud = 2'd3;
        idle_bits(2);

        // 2: short low pulse is rejected as a false start
        chars_before = n_chars;
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        check("t2_busy_rise", 32'(busy), 32'd1);
        @(negedge clk);
        rx = 1'b1;
        wait_idle("t2_idle", 200);
        idle_bits(2);
        check("t2_no_char", 32'(n_chars - chars_before), 32'd0);

        // 3: one-tick glitch at mid bit 3 is outvoted
        sb_q.push_back('{data: 8'h00, frame_err: 1'b0, parity_err: 1'b0});
        send_frame(8'h00, Div3, 1'b0, 1'b0, 1'b1, 3, 99);
        wait_idle("t3_idle", 200);
        idle_bits(2);

        // 4: stop bit 0 then a long break
        chars_before = n_chars;
        sb_q.push_back('{data: 8'h5A, frame_err: 1'b1, parity_err: 1'b0});
        send_frame(8'h5A, Div3, 1'b0, 1'b0, 1'b0, -1, 99);
        rx = 1'b0;
        repeat (40 * BitClk) @(negedge clk);
        check("t4_break_busy", 32'(busy), 32'd1);
        check("t4_single_commit", 32'(n_chars - chars_before), 32'd1);
        rx = 1'b1;
        wait_idle("t4_idle", 20);
        idle_bits(2);
        check("t4_no_extra", 32'(n_chars - chars_before), 32'd1);

        // 5: overrun while the consumer stalls
        @(posedge clk);
        #1 rx_if.ready = 1'b0;
        sb_q.push_back('{data: 8'h11, frame_err: 1'b0, parity_err: 1'b0});
        send_frame(8'h11, Div3, 1'b0, 1'b0, 1'b1, -1, 99);
        idle_bits(1);
        send_frame(8'h22, Div3, 1'b0, 1'b0, 1'b1, -1, 99);
        idle_bits(2);
        check("t5_overrun_once", 32'(n_ovr), 32'd1);
        check("t5_valid_held", 32'(rx_if.valid), 32'd1);
        check("t5_data_held", 32'(rx_if.data), 32'h11);
        @(posedge clk);
        #1 rx_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_valid_clear", 32'(rx_if.valid), 32'd0);
        idle_bits(1);

`ifdef UART_RX_PARITY_EN
        // 6: odd parity, good and bad parity bit
        parity_odd = 1'b1;
        sb_q.push_back('{data: 8'h07, frame_err: 1'b0, parity_err: 1'b0});
        send_frame(8'h07, Div3, 1'b1, 1'b0, 1'b1, -1, 99);
        idle_bits(2);
        sb_q.push_back('{data: 8'h07, frame_err: 1'b0, parity_err: 1'b1});
        send_frame(8'h07, Div3, 1'b1, 1'b1, 1'b1, -1, 99);
        idle_bits(2);
        parity_odd = 1'b0;
`endif

        // Reset in the middle of the data bits aborts the frame
        chars_before = n_chars;
        send_frame(8'h3C, Div3, 1'b0, 1'b0, 1'b1, -1, 4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(rx_if.valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ferr", 32'(rx_if.frame_err), 32'd0);
        check("rst_mid_ovr", 32'(rx_if.overrun), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(12);
        check("rst_mid_no_char", 32'(n_chars - chars_before), 32'd0);
        sb_q.push_back('{data: 8'h3C, frame_err: 1'b0, parity_err: 1'b0});
        send_frame(8'h3C, Div3, 1'b0, 1'b0, 1'b1, -1, 99);
        wait_idle("post_rst_idle", 200);
        idle_bits(2);
        check("post_rst_char", 32'(n_chars - chars_before), 32'd1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
